mmu_tile_ctrl: RTL and testbench

//  Sequencer for one MMU tile pass: weight load -> data stream -> psum drain.

---
 rtl/mmu_pkg.sv | 41 ++++
 rtl/mmu_step_counter.sv | 43 ++++
 rtl/mmu_tile_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mmu_tile_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared definitions for the MMU tile pass sequencer:
//   - state encoding of the tile-pass FSM
//   - clog2_min1(): ceil(log2(v)) clamped to at least one bit
//   - cnt_width(): width of the shared phase counter for N x N array, D vectors
// No ports (package).
// ---------------------------------------------------------------------------
package mmu_pkg;

    typedef logic [2:0] mmu_state_t;

    localparam mmu_state_t ST_IDLE    = 3'd0;
    localparam mmu_state_t ST_WLOAD   = 3'd1;
    localparam mmu_state_t ST_COMPUTE = 3'd2;
    localparam mmu_state_t ST_DRAIN   = 3'd3;
    localparam mmu_state_t ST_DONE    = 3'd4;

    // A zero-width bus is illegal, so single-entry ranges still get one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 32'sd1) ? 32'sd1 : $clog2(v);
    endfunction

    // The counter must reach N-1 (rows), D-1 (vectors) and 2N-2 (drain skew).
    function automatic int cnt_width(input int n, input int d);
        int m;
        m = n;
        if (d > m) begin
            m = d;
        end else begin
            m = m;
        end
        if ((32'sd2 * n - 32'sd1) > m) begin
            m = 32'sd2 * n - 32'sd1;
        end else begin
            m = m;
        end
        return clog2_min1(m);
    endfunction

endpackage

// File: rtl/mmu_step_counter.sv
// ---------------------------------------------------------------------------
// mmu_step_counter
// Up-counter shared by all phases of a tile pass. Clear has priority over
// enable; last_o flags that the count equals the phase's terminal value.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en           advance the count by one
//   clr          return the count to zero
//   term [W]     terminal value of the current phase
//   cnt  [W]     current count (registered)
//   last_o       cnt == term
// ---------------------------------------------------------------------------
module mmu_step_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         last_o
);

    logic [W-1:0] cnt_r;

    // Count register: clear wins over enable, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt    = cnt_r;
    assign last_o = (cnt_r == term);

endmodule

// File: rtl/mmu_tile_ctrl.sv
// ---------------------------------------------------------------------------
// mmu_tile_ctrl
// Sequences one MMU tile pass: weight load (N rows) -> data stream (D vectors)
// -> psum drain (2N-1 cycles) -> one-cycle done pulse. Outputs are decoded
// from the registered state and count; strobes are masked by stall_i.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start_i            start request, honoured only in IDLE
//   abort_i            synchronous abort to IDLE, highest priority
//   stall_i            freeze the current busy phase
//   weight_load_en_o   weight row write strobe
//   weight_row_o       weight row index (0 outside WLOAD)
//   data_valid_o       input vector valid strobe
//   data_idx_o         input vector index (0 outside COMPUTE)
//   drain_en_o         psum drain strobe
//   busy_o             high in WLOAD / COMPUTE / DRAIN
//   done_o             one-cycle completion pulse
//   stall_cycles_o     (only with MMU_CTRL_PERF_EN) saturating count of
//                      busy cycles spent stalled in the current/last pass
// Optional feature macro: MMU_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module mmu_tile_ctrl
    import mmu_pkg::*;
#(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_DEPTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start_i,
    input  logic                                abort_i,
    input  logic                                stall_i,
    output logic                                weight_load_en_o,
    output logic [clog2_min1(ARRAY_SIZE)-1:0]   weight_row_o,
    output logic                                data_valid_o,
    output logic [clog2_min1(DATA_DEPTH)-1:0]   data_idx_o,
    output logic                                drain_en_o,
    output logic                                busy_o,
    output logic                                done_o
`ifdef MMU_CTRL_PERF_EN
    ,
    output logic [31:0]                         stall_cycles_o
`endif
);

    localparam int RW = clog2_min1(ARRAY_SIZE);
    localparam int DW = clog2_min1(DATA_DEPTH);
    localparam int CW = cnt_width(ARRAY_SIZE, DATA_DEPTH);

    localparam logic [CW-1:0] TERM_WLOAD   = CW'(ARRAY_SIZE - 32'sd1);
    localparam logic [CW-1:0] TERM_COMPUTE = CW'(DATA_DEPTH - 32'sd1);
    localparam logic [CW-1:0] TERM_DRAIN   = CW'(32'sd2 * ARRAY_SIZE - 32'sd2);

    mmu_state_t    state_r;
    mmu_state_t    state_nxt_s;
    logic [CW-1:0] cnt_s;
    logic [CW-1:0] term_s;
    logic          last_s;
    logic          cnt_en_s;
    logic          cnt_clr_s;
    logic          busy_s;
    logic          start_acc_s;

    assign busy_s      = (state_r == ST_WLOAD) || (state_r == ST_COMPUTE) ||
                         (state_r == ST_DRAIN);
    assign start_acc_s = (state_r == ST_IDLE) && start_i && !abort_i;

    mmu_step_counter #(
        .W (CW)
    ) u_step_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cnt_en_s),
        .clr    (cnt_clr_s),
        .term   (term_s),
        .cnt    (cnt_s),
        .last_o (last_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: abort beats stall and start; a stalled terminal cycle waits.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_nxt_s = ST_WLOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WLOAD: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (!stall_i && last_s) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_WLOAD;
                end
            end
            ST_COMPUTE: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (!stall_i && last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (!stall_i && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Counter control: per-phase terminal select; the count is parked at zero
    // outside busy phases and restarts from zero at every phase change or abort.
    always_comb begin
        term_s    = '0;
        cnt_en_s  = 1'b0;
        cnt_clr_s = 1'b0;
        case (state_r)
            ST_WLOAD:   term_s = TERM_WLOAD;
            ST_COMPUTE: term_s = TERM_COMPUTE;
            ST_DRAIN:   term_s = TERM_DRAIN;
            default:    term_s = '0;
        endcase
        if (!busy_s || abort_i) begin
            cnt_clr_s = 1'b1;
        end else if (stall_i) begin
            cnt_clr_s = 1'b0;
        end else if (last_s) begin
            cnt_clr_s = 1'b1;
        end else begin
            cnt_en_s = 1'b1;
        end
    end

    // Output decode from registered state/count; strobes masked by stall.
    always_comb begin
        weight_load_en_o = 1'b0;
        weight_row_o     = '0;
        data_valid_o     = 1'b0;
        data_idx_o       = '0;
        drain_en_o       = 1'b0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_WLOAD: begin
                busy_o           = 1'b1;
                weight_load_en_o = !stall_i;
                weight_row_o     = cnt_s[RW-1:0];
            end
            ST_COMPUTE: begin
                busy_o       = 1'b1;
                data_valid_o = !stall_i;
                data_idx_o   = cnt_s[DW-1:0];
            end
            ST_DRAIN: begin
                busy_o     = 1'b1;
                drain_en_o = !stall_i;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

`ifdef MMU_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;

    // Stall-cycle counter: cleared on accepted start, saturating, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (start_acc_s) begin
            stall_cnt_r <= 32'd0;
        end else if (busy_s && stall_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_mmu_tile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmu_tile_ctrl
// Directed bench for mmu_tile_ctrl with N=4, D=8. Cycle c is the cycle after
// clock edge c, where edge 0 is the edge that accepts start_i.
// ---------------------------------------------------------------------------
module tb_mmu_tile_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       abort_i;
    logic       stall_i;
    logic       weight_load_en_o;
    logic [1:0] weight_row_o;
    logic       data_valid_o;
    logic [2:0] data_idx_o;
    logic       drain_en_o;
    logic       busy_o;
    logic       done_o;
`ifdef MMU_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] perf_at_done;
`endif

    int n_checks;
    int n_fail;
    int n_w, n_d, n_dr, n_done, n_busy;
    int done1, done2, w2_first, done_busy;
    int hold_from, hold_to;
    int n_act;
    bit stall_sched [0:63];
    bit abort_sched [0:63];

    mmu_tile_ctrl #(
        .ARRAY_SIZE (4),
        .DATA_DEPTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .stall_i          (stall_i),
        .weight_load_en_o (weight_load_en_o),
        .weight_row_o     (weight_row_o),
        .data_valid_o     (data_valid_o),
        .data_idx_o       (data_idx_o),
        .drain_en_o       (drain_en_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
`ifdef MMU_CTRL_PERF_EN
        ,
        .stall_cycles_o   (stall_cycles_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        foreach (stall_sched[i]) begin
            stall_sched[i] = 1'b0;
            abort_sched[i] = 1'b0;
        end
        hold_from = -1;
        hold_to   = -1;
    endtask

    // Issue a start, then run ncyc cycles applying the stall/abort schedules.
    task automatic run_pass(input int ncyc, input bit hold_start);
        int er;
        int ei;
        er = 0; ei = 0;
        n_w = 0; n_d = 0; n_dr = 0; n_done = 0; n_busy = 0;
        done1 = -1; done2 = -1; w2_first = -1; done_busy = 0;
        tick();
        start_i = 1'b1; stall_i = 1'b0; abort_i = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            start_i = hold_start;
            stall_i = stall_sched[c];
            abort_i = abort_sched[c];
            #1;
            if (weight_load_en_o) begin
                check("wrow", 32'(weight_row_o), 32'(er));
                er++; n_w++;
                if (done1 >= 0 && w2_first < 0) w2_first = c;
            end
            if (data_valid_o) begin
                check("didx", 32'(data_idx_o), 32'(ei));
                ei++; n_d++;
            end
            if (c >= hold_from && c <= hold_to) begin
                check("hold_idx", 32'(data_idx_o), 32'd5);
                check("hold_valid", 32'(data_valid_o), 32'd0);
            end
            if (drain_en_o) n_dr++;
            if (busy_o) n_busy++;
            if (done_o) begin
                n_done++;
                if (busy_o) done_busy = 1;
                if (done1 < 0) done1 = c; else done2 = c;
`ifdef MMU_CTRL_PERF_EN
                perf_at_done = stall_cycles_o;
`endif
                er = 0; ei = 0;
            end
        end
        start_i = 1'b0; stall_i = 1'b0; abort_i = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0;
        clear_sched();
        #12;
        check("reset_outs", 32'({weight_load_en_o, weight_row_o, data_valid_o, data_idx_o,
                                 drain_en_o, busy_o, done_o}), 32'd0);
        rst_n = 1'b1;

        // 1: clean pass
        run_pass(22, 1'b0);
        check("t1_wcount", 32'(n_w), 32'd4);
        check("t1_dcount", 32'(n_d), 32'd8);
        check("t1_drcount", 32'(n_dr), 32'd7);
        check("t1_done_cyc", 32'(done1), 32'd20);
        check("t1_ndone", 32'(n_done), 32'd1);
        check("t1_busy_cycles", 32'(n_busy), 32'd19);
        check("t1_busy_at_done", 32'(done_busy), 32'd0);

        // 2: 3-cycle stall while COMPUTE holds index 5
        clear_sched();
        stall_sched[10] = 1'b1; stall_sched[11] = 1'b1; stall_sched[12] = 1'b1;
        hold_from = 10; hold_to = 12;
        run_pass(26, 1'b0);
        check("t2_dcount", 32'(n_d), 32'd8);
        check("t2_done_cyc", 32'(done1), 32'd23);
        check("t2_busy_cycles", 32'(n_busy), 32'd22);

        // 3: abort in DRAIN, then a clean pass
        clear_sched();
        abort_sched[15] = 1'b1;
        run_pass(22, 1'b0);
        check("t3_ndone", 32'(n_done), 32'd0);
        check("t3_drcount", 32'(n_dr), 32'd3);
        check("t3_busy_cycles", 32'(n_busy), 32'd15);
        clear_sched();
        run_pass(22, 1'b0);
        check("t3b_wcount", 32'(n_w), 32'd4);
        check("t3b_done_cyc", 32'(done1), 32'd20);

        // abort in IDLE blocks start
        tick();
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        #1;
        check("idle_abort_blocks", 32'(busy_o), 32'd0);

        // 4: start held high -> back-to-back passes
        clear_sched();
        run_pass(41, 1'b1);
        check("t4_done1", 32'(done1), 32'd20);
        check("t4_done2", 32'(done2), 32'd41);
        check("t4_second_wload", 32'(w2_first), 32'd22);
        check("t4_wcount", 32'(n_w), 32'd8);
        check("t4_busy_cycles", 32'(n_busy), 32'd38);
        tick();

        // 5: async reset mid-WLOAD
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        #1;
        check("t5_pre_wen", 32'(weight_load_en_o), 32'd1);
        check("t5_pre_row", 32'(weight_row_o), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'({weight_load_en_o, weight_row_o, data_valid_o, data_idx_o,
                                  drain_en_o, busy_o, done_o}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_act = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy_o || weight_load_en_o || data_valid_o || drain_en_o || done_o) n_act++;
        end
        check("t5_quiet", 32'(n_act), 32'd0);
        run_pass(22, 1'b0);
        check("t5_wcount", 32'(n_w), 32'd4);
        check("t5_done_cyc", 32'(done1), 32'd20);

`ifdef MMU_CTRL_PERF_EN
        // 6: stall counter, stalls of 2 and 5 cycles
        clear_sched();
        stall_sched[6] = 1'b1; stall_sched[7] = 1'b1;
        for (int i = 16; i <= 20; i++) stall_sched[i] = 1'b1;
        run_pass(27, 1'b0);
        check("t6_done_cyc", 32'(done1), 32'd27);
        check("t6_perf_at_done", perf_at_done, 32'd7);
        tick();
        check("t6_perf_hold", stall_cycles_o, 32'd7);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t6_perf_clear", stall_cycles_o, 32'd0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
